led_sequencer: RTL and testbench

- Downstream consumer of the switch-selectable rate counter's single-cycle o_valid tick.
- Drives an LED bank with a pattern that advances by one step per tick.
- The pattern mode is chosen by push-buttons through rising-edge detection.
- Sits between the tick generator and the board LED pins; all outputs are registered.

---
 rtl/led_sequencer.sv | 140 ++++++++++++++
 tb/tb_led_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_sequencer.sv
// led_sequencer: steps an LED bank pattern once per i_valid tick.
// The pattern mode is picked by a rising edge on a push-button.
// Define LED_BTN_SYNC_EN to put a 2-flop synchronizer on i_btn.
// Without it, i_btn is used directly by the edge detector.
//
// state    | meaning
// ---------+-----------------------------------------------
// ROT_L    | single lit LED rotates toward MSB, MSB wraps to LSB
// ROT_R    | single lit LED rotates toward LSB, LSB wraps to MSB
// FLASH    | whole bank toggles between all-on and all-off
// PINGPONG | single lit LED bounces between the two ends
module led_sequencer #(
    parameter int NB_LED = 4,
    parameter int NB_BTN = 4
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [NB_BTN-1:0] i_btn,
    output logic [NB_LED-1:0] o_led,
    output logic [1:0]        o_mode
);

    typedef enum logic [1:0] {
        ROT_L    = 2'd0,
        ROT_R    = 2'd1,
        FLASH    = 2'd2,
        PINGPONG = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    // Only four modes exist, so buttons above index 3 are dropped.
    localparam int NB_USE = (NB_BTN < 4) ? NB_BTN : 4;
    localparam logic [NB_LED-1:0] LED_LSB = {{(NB_LED-1){1'b0}}, 1'b1};
    localparam logic [NB_LED-1:0] LED_MSB = {1'b1, {(NB_LED-1){1'b0}}};

    logic [NB_BTN-1:0] btn_s;
    logic [3:0]        btn_use;
    logic [3:0]        btn_prev;
    logic [3:0]        btn_rise;

    mode_t             mode_q, mode_d;
    dir_t              dir_q, dir_d;
    logic [NB_LED-1:0] led_q, led_d;

`ifdef LED_BTN_SYNC_EN
    logic [NB_BTN-1:0] sync_1;
    logic [NB_BTN-1:0] sync_2;

    // Two-flop synchronizer for the asynchronous push-buttons.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= i_btn;
            sync_2 <= sync_1;
        end
    end

    assign btn_s = sync_2;
`else
    assign btn_s = i_btn;
`endif

    // Narrow the button vector to the four mode-select buttons.
    always_comb begin
        btn_use               = '0;
        btn_use[NB_USE-1:0]   = btn_s[NB_USE-1:0];
    end

    assign btn_rise = btn_use & ~btn_prev;

    // Next pattern: a button rise reloads (and drops any tick), else a tick steps.
    always_comb begin
        mode_d = mode_q;
        dir_d  = dir_q;
        led_d  = led_q;
        if (btn_rise != 4'd0) begin
            if (btn_rise[0])      mode_d = ROT_L;
            else if (btn_rise[1]) mode_d = ROT_R;
            else if (btn_rise[2]) mode_d = FLASH;
            else                  mode_d = PINGPONG;
            dir_d = DIR_LEFT;
            case (mode_d)
                ROT_L:    led_d = LED_LSB;
                ROT_R:    led_d = LED_MSB;
                FLASH:    led_d = '1;
                PINGPONG: led_d = LED_LSB;
            endcase
        end else if (i_valid) begin
            case (mode_q)
                ROT_L:    led_d = {led_q[NB_LED-2:0], led_q[NB_LED-1]};
                ROT_R:    led_d = {led_q[0], led_q[NB_LED-1:1]};
                FLASH:    led_d = ~led_q;
                PINGPONG: begin
                    // Reverse in the same step so the end LED is not lit twice.
                    if (dir_q == DIR_LEFT) begin
                        if (led_q[NB_LED-1]) begin
                            dir_d = DIR_RIGHT;
                            led_d = led_q >> 1;
                        end else begin
                            led_d = led_q << 1;
                        end
                    end else begin
                        if (led_q[0]) begin
                            dir_d = DIR_LEFT;
                            led_d = led_q << 1;
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end
                end
            endcase
        end
    end

    // State register; reset wins over ticks and buttons.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            mode_q   <= ROT_L;
            dir_q    <= DIR_LEFT;
            led_q    <= LED_LSB;
            btn_prev <= '0;
        end else begin
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            led_q    <= led_d;
            btn_prev <= btn_use;
        end
    end

    assign o_led  = led_q;
    assign o_mode = mode_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Testbench for led_sequencer: directed literal checks plus randomized
// stimulus compared every cycle against a position-based model.
module tb_led_sequencer;

    localparam int NB_LED = 4;
    localparam int NB_BTN = 4;
`ifdef LED_BTN_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic              clk;
    logic              i_reset;
    logic              i_valid;
    logic [NB_BTN-1:0] i_btn;
    logic [NB_LED-1:0] o_led;
    logic [1:0]        o_mode;

    int checks   = 0;
    int failures = 0;

    led_sequencer #(.NB_LED(NB_LED), .NB_BTN(NB_BTN)) dut (
        .clk     (clk),
        .i_reset (i_reset),
        .i_valid (i_valid),
        .i_btn   (i_btn),
        .o_led   (o_led),
        .o_mode  (o_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: lit position and direction, flash phase, delayed button history.
    bit        m_ok  = 1'b0;
    int        m_mode = 0;
    int        m_pos  = 0;
    int        m_dir  = 1;
    bit        m_on   = 1'b0;
    bit [3:0]  m_prev = '0;
    bit [3:0]  m_hist [0:2];

    function automatic logic [NB_LED-1:0] m_led();
        if (m_mode == 2) return m_on ? '1 : '0;
        return NB_LED'(1) << m_pos;
    endfunction

    always @(posedge clk) begin
        bit [3:0] bs;
        bit [3:0] rise;
        if (i_reset) begin
            m_ok   = 1'b1;
            m_mode = 0;
            m_pos  = 0;
            m_dir  = 1;
            m_on   = 1'b0;
            m_prev = '0;
            for (int i = 0; i < 3; i++) m_hist[i] = '0;
        end else begin
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = i_btn[3:0];
            bs     = m_hist[LAT-1];
            rise   = bs & ~m_prev;
            m_prev = bs;
            if (rise != 0) begin
                for (int k = 3; k >= 0; k--) if (rise[k]) m_mode = k;
                m_pos = (m_mode == 1) ? NB_LED - 1 : 0;
                m_dir = 1;
                m_on  = 1'b1;
            end else if (i_valid && m_ok) begin
                case (m_mode)
                    0: m_pos = (m_pos + 1) % NB_LED;
                    1: m_pos = (m_pos + NB_LED - 1) % NB_LED;
                    2: m_on  = !m_on;
                    default: begin
                        if (m_pos + m_dir < 0 || m_pos + m_dir >= NB_LED) m_dir = -m_dir;
                        m_pos = m_pos + m_dir;
                    end
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model on every cycle after the first reset.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("cmp_led", 32'(o_led), 32'(m_led()));
            chk("cmp_mode", 32'(o_mode), 32'(m_mode));
        end
    end

    task automatic do_reset();
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_btn   = '0;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
    endtask

    task automatic tick();
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic press(input logic [NB_BTN-1:0] b);
        i_btn = b;
        @(negedge clk);
        i_btn = '0;
        repeat (LAT + 1) @(negedge clk);
    endtask

    logic [NB_LED-1:0] exp_rl [0:4]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [NB_LED-1:0] exp_rr [0:3]  = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    logic [NB_LED-1:0] exp_pp [0:8]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010,
                                         4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [NB_LED-1:0] exp_fl [0:2]  = '{4'b0000, 4'b1111, 4'b0000};

    initial begin
        i_reset = 1'b0;
        i_valid = 1'b0;
        i_btn   = '0;
        @(negedge clk);

        do_reset();
        chk("rst_led", 32'(o_led), 32'b0001);
        chk("rst_mode", 32'(o_mode), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rotl_led", 32'(o_led), 32'(exp_rl[i]));
        end
        chk("rotl_mode", 32'(o_mode), 32'd0);

        press(4'b0010);
        chk("rotr_reload", 32'(o_led), 32'b1000);
        chk("rotr_mode", 32'(o_mode), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rotr_led", 32'(o_led), 32'(exp_rr[i]));
        end

        press(4'b1000);
        chk("pp_reload", 32'(o_led), 32'b0001);
        chk("pp_mode", 32'(o_mode), 32'd3);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("pp_led", 32'(o_led), 32'(exp_pp[i]));
        end

        // Rise of buttons 1 and 2 together with a tick: button 1 wins.
        i_btn   = 4'b0110;
        i_valid = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        chk("simul_mode", 32'(o_mode), 32'd1);
        chk("simul_led", 32'(o_led), 32'b1000);
        repeat (5) @(negedge clk);
        tick();
        chk("held_no_reload", 32'(o_led), 32'b0100);
        i_btn = '0;
        repeat (LAT + 1) @(negedge clk);

        press(4'b0100);
        chk("flash_reload", 32'(o_led), 32'b1111);
        chk("flash_mode", 32'(o_mode), 32'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("flash_led", 32'(o_led), 32'(exp_fl[i]));
        end
        i_reset = 1'b1;
        i_valid = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        i_valid = 1'b0;
        chk("rst_tick_led", 32'(o_led), 32'b0001);
        chk("rst_tick_mode", 32'(o_mode), 32'd0);
        @(negedge clk);

        // Button latency: mode must change exactly LAT edges after press.
        i_btn = 4'b0010;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("btn_latency", 32'(o_mode), (j + 1 >= LAT) ? 32'd1 : 32'd0);
            i_btn = '0;
        end
        repeat (2) @(negedge clk);

        // Button already high while reset releases.
        i_reset = 1'b1;
        i_btn   = 4'b0100;
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        repeat (LAT) @(negedge clk);
        chk("btn_after_rst_mode", 32'(o_mode), 32'd2);
        chk("btn_after_rst_led", 32'(o_led), 32'b1111);
        i_btn = '0;
        @(negedge clk);

        // Randomized phase, checked by the compare process.
        for (int n = 0; n < 3000; n++) begin
            i_reset = ($urandom_range(0, 199) == 0);
            i_valid = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) i_btn = NB_BTN'($urandom);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
